// File: rtl/mat_row_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_row_bank_if                                                            |
// | Host load/drain and engine read/write-back signals of mat_row_bank.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mat_row_bank_if #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
);
  localparam int c_ROW_W = SIZE * 2 * WIDTH;
  localparam int c_AW    = $clog2(SIZE);

  logic               flush_i;
  logic               load_start_i;
  logic [c_ROW_W-1:0] load_row_i;
  logic               load_valid_i;
  logic               load_ready_o;
  logic [c_AW-1:0]    rd_addr_i;
  logic               rd_addr_valid_i;
  logic [c_ROW_W-1:0] rd_row_o;
  logic [c_AW-1:0]    rd_addr_o;
  logic               rd_valid_o;
  logic [c_ROW_W-1:0] wr_row_i;
  logic [c_AW-1:0]    wr_addr_i;
  logic               wr_valid_i;
  logic               wr_ready_o;
  logic               drain_start_i;
  logic               drain_transpose_i;
  logic [c_ROW_W-1:0] drain_row_o;
  logic [c_AW-1:0]    drain_addr_o;
  logic               drain_valid_o;
  logic               drain_ready_i;
  logic               full_o;
  logic               busy_o;

  modport master (
    output flush_i, load_start_i, load_row_i, load_valid_i,
           rd_addr_i, rd_addr_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
           drain_start_i, drain_transpose_i, drain_ready_i,
    input  load_ready_o, rd_row_o, rd_addr_o, rd_valid_o, wr_ready_o,
           drain_row_o, drain_addr_o, drain_valid_o, full_o, busy_o
  );

  modport slave (
    input  flush_i, load_start_i, load_row_i, load_valid_i,
           rd_addr_i, rd_addr_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
           drain_start_i, drain_transpose_i, drain_ready_i,
    output load_ready_o, rd_row_o, rd_addr_o, rd_valid_o, wr_ready_o,
           drain_row_o, drain_addr_o, drain_valid_o, full_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/mat_row_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_row_bank                                                               |
// | SIZE x SIZE complex row store: host load/drain (optional transpose) and    |
// | engine 1-cycle row read plus row write-back.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mat_row_bank #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
) (
  input wire           clk_i,
  input wire           rst_i,
  mat_row_bank_if.slave bus
);
  localparam int              c_ELEM_W = 2 * WIDTH;
  localparam int              c_ROW_W  = SIZE * c_ELEM_W;
  localparam int              c_AW     = $clog2(SIZE);
  localparam logic [c_AW-1:0] c_LAST   = c_AW'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_AW-1:0]    r_cnt;
  logic               r_transpose;
  logic               r_full;
  logic               r_rd_valid;
  logic [c_ROW_W-1:0] r_rd_row;
  logic [c_AW-1:0]    r_rd_addr;
  logic               r_drain_valid;
  logic [c_ROW_W-1:0] r_drain_row;
  logic [c_AW-1:0]    r_drain_addr;
  logic [c_ROW_W-1:0] r_mem [SIZE];

  logic               w_load_fire;
  logic               w_wr_fire;
  logic               w_drain_go;
  logic               w_drain_fire;
  logic [c_AW-1:0]    w_drain_idx;
  logic               w_drain_tp;
  logic [c_ROW_W-1:0] w_drain_row;
  logic [c_ROW_W-1:0] w_col [SIZE];

  // w_col[k] is column k of the stored matrix laid out as a row
  for (genvar k = 0; k < SIZE; k++) begin : g_col
    for (genvar j = 0; j < SIZE; j++) begin : g_elem
      assign w_col[k][j*c_ELEM_W +: c_ELEM_W] = r_mem[j][k*c_ELEM_W +: c_ELEM_W];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_fire  = 1'b0;
    w_wr_fire    = 1'b0;
    w_drain_go   = 1'b0;
    w_drain_fire = 1'b0;
    if (bus.flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load_start_i) w_state_next = ST_LOAD;
        end
        ST_LOAD: begin
          if (bus.load_valid_i) begin
            w_load_fire = 1'b1;
            if (r_cnt == c_LAST) w_state_next = ST_SERVE;
          end
        end
        ST_SERVE: begin
          w_wr_fire = bus.wr_valid_i;
          if (bus.load_start_i) begin
            w_state_next = ST_LOAD;
          end else if (bus.drain_start_i) begin
            w_state_next = ST_DRAIN;
            w_drain_go   = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_valid && bus.drain_ready_i) begin
            w_drain_fire = 1'b1;
            if (r_cnt == c_LAST) w_state_next = ST_SERVE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Next drain beat is prepared one cycle early so drain_valid_o stays registered
  assign w_drain_idx = w_drain_go ? '0 : r_cnt + 1'b1;
  assign w_drain_tp  = w_drain_go ? bus.drain_transpose_i : r_transpose;
  assign w_drain_row = w_drain_tp ? w_col[w_drain_idx] : r_mem[w_drain_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt         <= '0;
      r_transpose   <= 1'b0;
      r_full        <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_row      <= '0;
      r_rd_addr     <= '0;
      r_drain_valid <= 1'b0;
      r_drain_row   <= '0;
      r_drain_addr  <= '0;
    end else begin
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_load_fire || w_drain_fire) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (bus.flush_i || (r_state != ST_LOAD && w_state_next == ST_LOAD)) begin
        r_full <= 1'b0;
      end else if (w_load_fire && r_cnt == c_LAST) begin
        r_full <= 1'b1;
      end

      r_rd_valid <= (r_state == ST_SERVE) && bus.rd_addr_valid_i && !bus.flush_i;
      if ((r_state == ST_SERVE) && bus.rd_addr_valid_i && !bus.flush_i) begin
        r_rd_row  <= r_mem[bus.rd_addr_i];
        r_rd_addr <= bus.rd_addr_i;
      end

      if (w_drain_go) r_transpose <= bus.drain_transpose_i;
      r_drain_valid <= (w_state_next == ST_DRAIN);
      if (w_drain_go || (w_drain_fire && w_state_next == ST_DRAIN)) begin
        r_drain_row  <= w_drain_row;
        r_drain_addr <= w_drain_idx;
      end
    end
  end

  // Storage is deliberately not reset; it holds whatever was last written
  always_ff @(posedge clk_i) begin
    if (w_load_fire) r_mem[r_cnt] <= bus.load_row_i;
    if (w_wr_fire)   r_mem[bus.wr_addr_i] <= bus.wr_row_i;
  end

  assign bus.load_ready_o  = (r_state == ST_LOAD);
  assign bus.wr_ready_o    = (r_state == ST_SERVE);
  assign bus.busy_o        = (r_state != ST_IDLE);
  assign bus.full_o        = r_full;
  assign bus.rd_valid_o    = r_rd_valid;
  assign bus.rd_row_o      = r_rd_row;
  assign bus.rd_addr_o     = r_rd_addr;
  assign bus.drain_valid_o = r_drain_valid;
  assign bus.drain_row_o   = r_drain_row;
  assign bus.drain_addr_o  = r_drain_addr;
endmodule
`default_nettype wire

// File: tb/tb_mat_row_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mat_row_bank                                                            |
// | Scenario bench for mat_row_bank against an array model of the matrix.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mat_row_bank;
  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int E     = 2 * WIDTH;
  localparam int ROW_W = SIZE * E;
  localparam int AW    = $clog2(SIZE);
  typedef logic [ROW_W-1:0] row_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  row_t model [SIZE];

  mat_row_bank_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();
  mat_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  function automatic row_t rand_row();
    row_t r;
    for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic row_t model_col(input int k);
    row_t r;
    for (int j = 0; j < SIZE; j++) r[j*E +: E] = model[j][k*E +: E];
    return r;
  endfunction

  function automatic int diff_at(input row_t a, input row_t b);
    for (int j = 0; j < SIZE; j++) if (a[j*E +: E] !== b[j*E +: E]) return j;
    return 0;
  endfunction

  task automatic idle_inputs();
    bus.flush_i = 0; bus.load_start_i = 0; bus.load_row_i = '0; bus.load_valid_i = 0;
    bus.rd_addr_i = '0; bus.rd_addr_valid_i = 0; bus.wr_row_i = '0; bus.wr_addr_i = '0;
    bus.wr_valid_i = 0; bus.drain_start_i = 0; bus.drain_transpose_i = 0; bus.drain_ready_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({bus.load_ready_o, bus.wr_ready_o, bus.full_o, bus.busy_o, bus.rd_valid_o, bus.drain_valid_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.load_ready_o, bus.wr_ready_o, bus.full_o, bus.busy_o, bus.rd_valid_o, bus.drain_valid_o});
    end
    n_checks++;
    if (bus.rd_row_o !== '0 || bus.drain_row_o !== '0 || bus.rd_addr_o !== '0 || bus.drain_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rd_addr=%0d drain_addr=%0d rows_zero=%b/%b expected 0 0 1/1",
               bus.rd_addr_o, bus.drain_addr_o, bus.rd_row_o == '0, bus.drain_row_o == '0);
    end
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b expected 0", bus.busy_o);
    end
  endtask

  task automatic load_model(input bit gaps);
    int i;
    bus.load_start_i = 1;
    @(posedge clk_i); #1;
    bus.load_start_i = 0;
    n_checks++;
    if (bus.load_ready_o !== 1'b1 || bus.full_o !== 1'b0) begin
      n_fail++; $display("FAIL load_enter: load_ready=%b full=%b expected 1 0", bus.load_ready_o, bus.full_o);
    end
    i = 0;
    while (i < SIZE) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus.load_valid_i = 0;
      end else begin
        bus.load_valid_i = 1; bus.load_row_i = model[i]; i++;
      end
      @(posedge clk_i); #1;
      if (i < SIZE) begin
        n_checks++;
        if (bus.full_o !== 1'b0 || bus.load_ready_o !== 1'b1) begin
          n_fail++; $display("FAIL load_beat %0d: full=%b load_ready=%b expected 0 1", i, bus.full_o, bus.load_ready_o);
        end
      end
    end
    bus.load_valid_i = 0;
    n_checks++;
    if (bus.full_o !== 1'b1 || bus.load_ready_o !== 1'b0 || bus.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: full=%b load_ready=%b wr_ready=%b expected 1 0 1",
               bus.full_o, bus.load_ready_o, bus.wr_ready_o);
    end
  endtask

  task automatic test_read();
    int d;
    for (int a = 0; a <= SIZE; a++) begin
      bus.rd_addr_valid_i = (a < SIZE);
      bus.rd_addr_i = AW'(a);
      @(posedge clk_i); #1;
      n_checks++;
      if (a < SIZE) begin
        if (bus.rd_valid_o !== 1'b1 || bus.rd_addr_o !== AW'(a) || bus.rd_row_o !== model[a]) begin
          n_fail++; d = diff_at(bus.rd_row_o, model[a]);
          $display("FAIL read a=%0d: valid=%b addr=%0d elem%0d=%h expected 1 %0d %h",
                   a, bus.rd_valid_o, bus.rd_addr_o, d, bus.rd_row_o[d*E +: E], a, model[a][d*E +: E]);
        end
      end else if (bus.rd_valid_o !== 1'b0 || bus.rd_row_o !== model[SIZE-1]) begin
        n_fail++; $display("FAIL read_hold: valid=%b row_held=%b expected 0 1", bus.rd_valid_o, bus.rd_row_o === model[SIZE-1]);
      end
    end
  endtask

  task automatic test_collision();
    row_t seven, old;
    for (int j = 0; j < SIZE; j++) seven[j*E +: E] = {64'd0, $realtobits(7.0)};
    old = model[3];
    bus.rd_addr_valid_i = 1; bus.rd_addr_i = 3;
    bus.wr_valid_i = 1; bus.wr_addr_i = 3; bus.wr_row_i = seven;
    @(posedge clk_i); #1;
    bus.wr_valid_i = 0;
    model[3] = seven;
    n_checks++;
    if (bus.rd_valid_o !== 1'b1 || bus.rd_row_o !== old) begin
      n_fail++; $display("FAIL collision_old: valid=%b elem0=%h expected 1 %h", bus.rd_valid_o, bus.rd_row_o[E-1:0], old[E-1:0]);
    end
    @(posedge clk_i); #1;
    bus.rd_addr_valid_i = 0;
    n_checks++;
    if (bus.rd_row_o !== seven) begin
      n_fail++; $display("FAIL collision_new: elem0=%h expected %h", bus.rd_row_o[E-1:0], seven[E-1:0]);
    end
  endtask

  task automatic test_random_rw();
    bit exp_v; int exp_a, d; row_t exp_row;
    for (int c = 0; c < 48; c++) begin
      bus.rd_addr_valid_i = $urandom_range(1);
      bus.rd_addr_i       = AW'($urandom_range(SIZE-1));
      bus.wr_valid_i      = $urandom_range(1);
      bus.wr_addr_i       = AW'($urandom_range(SIZE-1));
      bus.wr_row_i        = rand_row();
      exp_v = bus.rd_addr_valid_i; exp_a = int'(bus.rd_addr_i); exp_row = model[exp_a];
      if (bus.wr_valid_i) model[bus.wr_addr_i] = bus.wr_row_i;
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.rd_valid_o !== exp_v || (exp_v && (bus.rd_addr_o !== AW'(exp_a) || bus.rd_row_o !== exp_row))) begin
        n_fail++; d = diff_at(bus.rd_row_o, exp_row);
        $display("FAIL random_rw c=%0d: valid=%b addr=%0d elem%0d=%h expected %b %0d %h",
                 c, bus.rd_valid_o, bus.rd_addr_o, d, bus.rd_row_o[d*E +: E], exp_v, exp_a, exp_row[d*E +: E]);
      end
    end
    bus.rd_addr_valid_i = 0; bus.wr_valid_i = 0;
  endtask

  // mode 0: ready always high, 1: ready 0101... starting low, 2: random ready
  task automatic test_drain(input bit tp, input int mode);
    int k, cyc, d; bit rdy, stall; row_t prev_row, exp_row; logic [AW-1:0] prev_addr;
    bus.drain_start_i = 1; bus.drain_transpose_i = tp;
    @(posedge clk_i); #1;
    bus.drain_start_i = 0; bus.drain_transpose_i = ~tp;
    k = 0; cyc = 0; stall = 0; prev_row = '0; prev_addr = '0;
    while (k < SIZE && cyc < 4 * SIZE) begin
      cyc++;
      n_checks++;
      if (bus.drain_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL drain_valid k=%0d cyc=%0d: got %b expected 1", k, cyc, bus.drain_valid_o);
      end
      if (stall) begin
        n_checks++;
        if (bus.drain_row_o !== prev_row || bus.drain_addr_o !== prev_addr) begin
          n_fail++; $display("FAIL drain_hold k=%0d: addr=%0d expected %0d row_same=%b", k, bus.drain_addr_o, prev_addr, bus.drain_row_o === prev_row);
        end
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = 1'($urandom_range(1));
      bus.drain_ready_i = rdy;
      if (rdy && bus.drain_valid_o === 1'b1) begin
        exp_row = tp ? model_col(k) : model[k];
        n_checks++;
        if (bus.drain_row_o !== exp_row || bus.drain_addr_o !== AW'(k)) begin
          n_fail++; d = diff_at(bus.drain_row_o, exp_row);
          $display("FAIL drain_beat tp=%0d k=%0d: addr=%0d elem%0d=%h expected %0d %h",
                   tp, k, bus.drain_addr_o, d, bus.drain_row_o[d*E +: E], k, exp_row[d*E +: E]);
        end
        k++;
      end
      stall = !rdy; prev_row = bus.drain_row_o; prev_addr = bus.drain_addr_o;
      @(posedge clk_i); #1;
    end
    bus.drain_ready_i = 0;
    n_checks++;
    if (k != SIZE || bus.drain_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1 ||
        (mode == 0 && cyc != SIZE) || (mode == 1 && cyc != 2 * SIZE)) begin
      n_fail++; $display("FAIL drain_end mode=%0d: beats=%0d cycles=%0d valid=%b wr_ready=%b expected %0d beats, valid 0, wr_ready 1",
                         mode, k, cyc, bus.drain_valid_o, bus.wr_ready_o, SIZE);
    end
  endtask

  task automatic test_flush();
    row_t newr [SIZE];
    for (int i = 0; i < SIZE; i++) newr[i] = rand_row();
    bus.load_start_i = 1;
    @(posedge clk_i); #1;
    bus.load_start_i = 0;
    for (int i = 0; i <= 8; i++) begin
      bus.load_valid_i = 1; bus.load_row_i = newr[i];
      bus.flush_i = (i == 8);
      @(posedge clk_i); #1;
    end
    bus.flush_i = 0; bus.load_valid_i = 0;
    for (int i = 0; i < 8; i++) model[i] = newr[i];
    n_checks++;
    if (bus.load_ready_o !== 1'b0 || bus.full_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL flush: load_ready=%b full=%b busy=%b wr_ready=%b expected 0 0 0 0",
                         bus.load_ready_o, bus.full_o, bus.busy_o, bus.wr_ready_o);
    end
    // reload, then hit reset asynchronously in the middle of a drain
    for (int i = 0; i < SIZE; i++) model[i] = rand_row();
    load_model(1);
    bus.drain_start_i = 1; bus.drain_ready_i = 1;
    @(posedge clk_i); #1;
    bus.drain_start_i = 0;
    repeat (3) begin @(posedge clk_i); #1; end
    n_checks++;
    if (bus.drain_valid_o !== 1'b1 || bus.drain_addr_o !== AW'(3) || bus.drain_row_o !== model[3]) begin
      n_fail++; $display("FAIL pre_reset_drain: valid=%b addr=%0d expected 1 3", bus.drain_valid_o, bus.drain_addr_o);
    end
    #3 rst_i = 1;
    #1;
    n_checks++;
    if ({bus.load_ready_o, bus.wr_ready_o, bus.full_o, bus.busy_o, bus.rd_valid_o, bus.drain_valid_o} !== 6'b0 ||
        bus.drain_row_o !== '0 || bus.drain_addr_o !== '0 || bus.rd_row_o !== '0 || bus.rd_addr_o !== '0) begin
      n_fail++; $display("FAIL async_reset: flags=%b drain_addr=%0d drain_row_zero=%b expected 000000 0 1",
                         {bus.load_ready_o, bus.wr_ready_o, bus.full_o, bus.busy_o, bus.rd_valid_o, bus.drain_valid_o},
                         bus.drain_addr_o, bus.drain_row_o == '0);
    end
    idle_inputs();
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_illegal();
    int d;
    // IDLE: read, write, load and drain handshakes all ignored
    bus.rd_addr_valid_i = 1; bus.wr_valid_i = 1; bus.wr_addr_i = 2; bus.wr_row_i = rand_row();
    bus.load_valid_i = 1; bus.drain_ready_i = 1;
    repeat (3) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.drain_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL idle_ignore: rd_valid=%b wr_ready=%b busy=%b drain_valid=%b expected 0 0 0 0",
                           bus.rd_valid_o, bus.wr_ready_o, bus.busy_o, bus.drain_valid_o);
      end
    end
    bus.load_valid_i = 0; bus.drain_ready_i = 0;
    for (int i = 0; i < SIZE; i++) model[i] = rand_row();
    bus.load_start_i = 1;
    @(posedge clk_i); #1;
    bus.load_start_i = 0;
    for (int i = 0; i < SIZE; i++) begin
      bus.load_valid_i = 1; bus.load_row_i = model[i];
      bus.rd_addr_i = AW'($urandom_range(SIZE-1)); bus.wr_addr_i = AW'($urandom_range(SIZE-1)); bus.wr_row_i = rand_row();
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.rd_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL load_read_ignored beat %0d: rd_valid=%b expected 0", i, bus.rd_valid_o);
      end
    end
    bus.load_valid_i = 0; bus.rd_addr_valid_i = 0; bus.wr_valid_i = 0;
    // load beat in SERVE, then write attempts during DRAIN: none may land
    bus.load_valid_i = 1; bus.load_row_i = rand_row();
    @(posedge clk_i); #1;
    bus.load_valid_i = 0;
    bus.drain_start_i = 1;
    @(posedge clk_i); #1;
    bus.drain_start_i = 0; bus.drain_ready_i = 1;
    bus.wr_valid_i = 1; bus.wr_addr_i = 5; bus.wr_row_i = rand_row();
    repeat (SIZE) begin @(posedge clk_i); #1; end
    bus.wr_valid_i = 0; bus.drain_ready_i = 0;
    n_checks++;
    if (bus.wr_ready_o !== 1'b1 || bus.drain_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL drain_return: wr_ready=%b drain_valid=%b expected 1 0", bus.wr_ready_o, bus.drain_valid_o);
    end
    for (int a = 0; a < SIZE; a++) begin
      bus.rd_addr_valid_i = 1; bus.rd_addr_i = AW'(a);
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.rd_valid_o !== 1'b1 || bus.rd_row_o !== model[a]) begin
        n_fail++; d = diff_at(bus.rd_row_o, model[a]);
        $display("FAIL illegal_intact a=%0d: valid=%b elem%0d=%h expected 1 %h",
                 a, bus.rd_valid_o, d, bus.rd_row_o[d*E +: E], model[a][d*E +: E]);
      end
    end
    bus.rd_addr_valid_i = 0;
    // both starts together: load wins
    bus.load_start_i = 1; bus.drain_start_i = 1;
    @(posedge clk_i); #1;
    bus.load_start_i = 0; bus.drain_start_i = 0;
    n_checks++;
    if (bus.load_ready_o !== 1'b1 || bus.drain_valid_o !== 1'b0 || bus.full_o !== 1'b0) begin
      n_fail++; $display("FAIL dual_start: load_ready=%b drain_valid=%b full=%b expected 1 0 0",
                         bus.load_ready_o, bus.drain_valid_o, bus.full_o);
    end
    bus.flush_i = 1;
    @(posedge clk_i); #1;
    bus.flush_i = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        model[i][j*E +: E] = {$realtobits(0.5 * i), $realtobits(i + 1.0)};
    load_model(0);
    test_read();
    test_collision();
    test_random_rw();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        model[i][j*E +: E] = E'(i * SIZE + j);
    load_model(1);
    test_drain(1'b1, 0);
    test_drain(1'b0, 1);
    test_drain(1'b1, 2);
    test_read();
    test_flush();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
